// File: rtl/mem_access_master.sv
// Bus master for the 8x8 latch-based memory unit: sequences each request as
// SETUP -> STROBE -> HOLD so address/op/data are stable whenever select is high.
module mem_access_master #(
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_write,
  output logic [7:0] rsp_rdata,
  output logic       mem_op,
  output logic       mem_select,
  output logic [2:0] mem_address,
  output logic [7:0] mem_in_bus,
  input  logic [7:0] mem_out_bus
);

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_RESP} state_t;

  state_t     r_state, w_state_next;
  logic [3:0] r_cnt, w_cnt_next;
  logic       r_req_ready, w_req_ready_next;
  logic       r_rsp_valid, w_rsp_valid_next;
  logic       r_rsp_write, w_rsp_write_next;
  logic [7:0] r_rsp_rdata, w_rsp_rdata_next;
  logic       r_mem_op, w_mem_op_next;
  logic       r_mem_select, w_mem_select_next;
  logic [2:0] r_mem_address, w_mem_address_next;
  logic [7:0] r_mem_in_bus, w_mem_in_bus_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 4'd0;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_write   <= 1'b0;
      r_rsp_rdata   <= 8'h00;
      r_mem_op      <= 1'b0;
      r_mem_select  <= 1'b0;
      r_mem_address <= 3'd0;
      r_mem_in_bus  <= 8'h00;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_req_ready   <= w_req_ready_next;
      r_rsp_valid   <= w_rsp_valid_next;
      r_rsp_write   <= w_rsp_write_next;
      r_rsp_rdata   <= w_rsp_rdata_next;
      r_mem_op      <= w_mem_op_next;
      r_mem_select  <= w_mem_select_next;
      r_mem_address <= w_mem_address_next;
      r_mem_in_bus  <= w_mem_in_bus_next;
    end
  end

  // Every output is computed one cycle ahead so the pins come straight from flops.
  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_req_ready_next   = r_req_ready;
    w_rsp_valid_next   = r_rsp_valid;
    w_rsp_write_next   = r_rsp_write;
    w_rsp_rdata_next   = r_rsp_rdata;
    w_mem_op_next      = r_mem_op;
    w_mem_select_next  = r_mem_select;
    w_mem_address_next = r_mem_address;
    w_mem_in_bus_next  = r_mem_in_bus;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_state_next       = ST_SETUP;
          w_req_ready_next   = 1'b0;
          w_mem_op_next      = req_write;
          w_mem_address_next = req_addr;
          w_mem_in_bus_next  = req_write ? req_wdata : 8'h00;
        end
      end
      ST_SETUP: begin
        w_state_next      = ST_STROBE;
        w_mem_select_next = 1'b1;
        w_cnt_next        = STROBE_LOAD;
      end
      ST_STROBE: begin
        if (r_cnt == 4'd0) begin
          w_state_next      = ST_HOLD;
          w_mem_select_next = 1'b0;
          w_cnt_next        = HOLD_LOAD;
          w_rsp_write_next  = r_mem_op;
          w_rsp_rdata_next  = r_mem_op ? 8'h00 : mem_out_bus;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == 4'd0) begin
          w_state_next     = ST_RESP;
          w_rsp_valid_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        // Address is left parked; only op and data return to their idle value.
        if (rsp_ready) begin
          w_state_next      = ST_IDLE;
          w_rsp_valid_next  = 1'b0;
          w_req_ready_next  = 1'b1;
          w_mem_op_next     = 1'b0;
          w_mem_in_bus_next = 8'h00;
        end
      end
      default: begin
        w_state_next      = ST_IDLE;
        w_mem_select_next = 1'b0;
        w_req_ready_next  = 1'b1;
        w_rsp_valid_next  = 1'b0;
      end
    endcase
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_write   = r_rsp_write;
  assign rsp_rdata   = r_rsp_rdata;
  assign mem_op      = r_mem_op;
  assign mem_select  = r_mem_select;
  assign mem_address = r_mem_address;
  assign mem_in_bus  = r_mem_in_bus;

endmodule

// File: tb/tb_mem_access_master.sv
// Bench for mem_access_master: default instance (S=2,H=1) and a S=1,H=3 instance,
// each attached to a behavioural 8x8 memory; both share the request/response inputs.
module tb_mem_access_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_write, rsp_ready;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;

  logic       a_req_ready, a_rsp_valid, a_rsp_write, a_op, a_sel;
  logic [7:0] a_rdata, a_in, a_out;
  logic [2:0] a_addr;
  logic       b_req_ready, b_rsp_valid, b_rsp_write, b_op, b_sel;
  logic [7:0] b_rdata, b_in, b_out;
  logic [2:0] b_addr;

  logic [7:0] mem_a [8];
  logic [7:0] mem_b [8];

  int total = 0;
  int bad   = 0;
  logic sel_b = 1'b0;

  always #5 clk = ~clk;

  mem_access_master u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_write(a_rsp_write),
    .rsp_rdata(a_rdata), .mem_op(a_op), .mem_select(a_sel), .mem_address(a_addr),
    .mem_in_bus(a_in), .mem_out_bus(a_out)
  );

  mem_access_master #(.STROBE_CYC(1), .HOLD_CYC(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_write(b_rsp_write),
    .rsp_rdata(b_rdata), .mem_op(b_op), .mem_select(b_sel), .mem_address(b_addr),
    .mem_in_bus(b_in), .mem_out_bus(b_out)
  );

  // Behavioural memories: written while selected in write mode, drive data only on a selected read.
  always @(posedge clk) begin
    if (a_sel && a_op) mem_a[a_addr] <= a_in;
    if (b_sel && b_op) mem_b[b_addr] <= b_in;
  end
  assign a_out = (a_sel && !a_op) ? mem_a[a_addr] : 8'h00;
  assign b_out = (b_sel && !b_op) ? mem_b[b_addr] : 8'h00;

  // Selected-instance view used by the tasks.
  logic       m_req_ready, m_rsp_valid, m_rsp_write, m_op, m_sel;
  logic [7:0] m_rdata, m_in;
  logic [2:0] m_addr;
  assign m_req_ready = sel_b ? b_req_ready : a_req_ready;
  assign m_rsp_valid = sel_b ? b_rsp_valid : a_rsp_valid;
  assign m_rsp_write = sel_b ? b_rsp_write : a_rsp_write;
  assign m_rdata     = sel_b ? b_rdata     : a_rdata;
  assign m_op        = sel_b ? b_op        : a_op;
  assign m_sel       = sel_b ? b_sel       : a_sel;
  assign m_addr      = sel_b ? b_addr      : a_addr;
  assign m_in        = sel_b ? b_in        : a_in;

  // Continuous check: op/address/in_bus must not move while select stays high.
  logic       pa_sel = 1'b0, pb_sel = 1'b0;
  logic [11:0] pa_bus, pb_bus;
  always @(negedge clk) begin
    if (a_sel && pa_sel) begin
      total++;
      if ({a_op, a_addr, a_in} !== pa_bus) begin
        bad++;
        $display("FAIL stable_a: got %0h expected %0h", {a_op, a_addr, a_in}, pa_bus);
      end
    end
    if (b_sel && pb_sel) begin
      total++;
      if ({b_op, b_addr, b_in} !== pb_bus) begin
        bad++;
        $display("FAIL stable_b: got %0h expected %0h", {b_op, b_addr, b_in}, pb_bus);
      end
    end
    pa_sel = a_sel; pa_bus = {a_op, a_addr, a_in};
    pb_sel = b_sel; pb_bus = {b_op, b_addr, b_in};
  end

  typedef struct {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;
  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic wr, input logic [2:0] addr, input logic [7:0] wdata);
    @(negedge clk);
    chk("req_ready_idle", 32'(m_req_ready), 32'd1);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
  endtask

  // Called right after the accepting edge; returns once rsp_valid is seen.
  task automatic wait_rsp(input logic wr, input logic [2:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp_rdata, input int exp_lat, input int exp_sel);
    int lat = 0, sel_cnt = 0, sel_first = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (m_sel) begin
        if (sel_cnt == 0) begin
          sel_first = k;
          chk("strobe_op", 32'(m_op), 32'(wr));
          chk("strobe_addr", 32'(m_addr), 32'(addr));
          chk("strobe_in_bus", 32'(m_in), 32'(wr ? wdata : 8'h00));
        end
        sel_cnt++;
      end
      if (m_rsp_valid) begin
        lat = k;
        break;
      end
    end
    chk("rsp_latency", lat, exp_lat);
    chk("sel_first_cycle", sel_first, 2);
    chk("sel_cycles", sel_cnt, exp_sel);
    chk("rsp_write", 32'(m_rsp_write), 32'(wr));
    chk("rsp_rdata", 32'(m_rdata), 32'(wr ? 8'h00 : exp_rdata));
    chk("req_ready_busy", 32'(m_req_ready), 32'd0);
  endtask

  // Response handshake with rsp_ready=1 at the next edge.
  task automatic finish_rsp(input logic [2:0] addr);
    @(posedge clk);
    @(negedge clk);
    chk("rsp_valid_cleared", 32'(m_rsp_valid), 32'd0);
    chk("req_ready_back", 32'(m_req_ready), 32'd1);
    chk("op_idle", 32'(m_op), 32'd0);
    chk("in_bus_idle", 32'(m_in), 32'd0);
    chk("addr_parked", 32'(m_addr), 32'(addr));
  endtask

  initial begin
    int ready_k;
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 3'd0; req_wdata = 8'h00; rsp_ready = 1'b1;

    vecs[0] = '{1'b1, 3'd3, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 3'd3, 8'h00, 8'hA5};
    for (int i = 0; i < 8; i++) begin
      vecs[2 + i]  = '{1'b1, 3'(i), 8'(i) ^ 8'h3C, 8'h00};
      vecs[10 + i] = '{1'b0, 3'(i), 8'h00, 8'(i) ^ 8'h3C};
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(a_req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_rsp_write", 32'(a_rsp_write), 32'd0);
    chk("rst_rsp_rdata", 32'(a_rdata), 32'd0);
    chk("rst_mem_bus", 32'({a_op, a_sel, a_addr, a_in}), 32'd0);
    rst_n = 1'b1;

    // Single write/read at 3, then the full address sweep
    for (int i = 0; i < 18; i++) begin
      send(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      wait_rsp(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 5, 2);
      finish_rsp(vecs[i].addr);
      $display("txn %0d: wr=%0d addr=%0d wdata=%02h rdata=%02h", i, vecs[i].wr,
               vecs[i].addr, vecs[i].wdata, a_rdata);
    end

    // Response backpressure for 4 cycles
    rsp_ready = 1'b0;
    send(1'b0, 3'd2, 8'h00);
    wait_rsp(1'b0, 3'd2, 8'h00, 8'h3E, 5, 2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", 32'(a_rsp_valid), 32'd1);
      chk("stall_rsp_rdata", 32'(a_rdata), 32'h3E);
      chk("stall_req_ready", 32'(a_req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    finish_rsp(3'd2);
    $display("txn stall: read addr=2 rdata=%02h", a_rdata);

    // req_valid held high while busy
    send(1'b1, 3'd1, 8'h11);
    ready_k = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_write = 1'b0;
        req_addr  = 3'd1;
        req_wdata = 8'h00;
      end
      if (a_req_ready) begin
        ready_k = k;
        break;
      end
    end
    chk("accept_spacing", ready_k, 6);
    @(posedge clk);
    wait_rsp(1'b0, 3'd1, 8'h00, 8'h11, 5, 2);
    finish_rsp(3'd1);
    $display("txn back-to-back: spacing=%0d rdata=%02h", ready_k, a_rdata);

    // Asynchronous reset during STROBE of a write
    send(1'b1, 3'd5, 8'hFF);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("strobe_before_reset", 32'(a_sel), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_sel_drop", 32'(a_sel), 32'd0);
    chk("async_req_ready", 32'(a_req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", 32'({a_rsp_valid, a_req_ready, a_sel}), 32'b010);
    end
    $display("txn reset: write addr=5 discarded");

    // Second instance: STROBE_CYC=1, HOLD_CYC=3
    sel_b = 1'b1;
    send(1'b1, 3'd7, 8'hC3);
    wait_rsp(1'b1, 3'd7, 8'hC3, 8'h00, 6, 1);
    finish_rsp(3'd7);
    $display("txn s1h3: write addr=7 wdata=c3");
    send(1'b0, 3'd7, 8'h00);
    wait_rsp(1'b0, 3'd7, 8'h00, 8'hC3, 6, 1);
    finish_rsp(3'd7);
    $display("txn s1h3: read addr=7 rdata=%02h", b_rdata);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
